somador_serial: RTL and testbench
=================================

Name: somador_serial

Overview:
Bit-serial add/subtract unit for the ULA. It wraps a single 1-bit full-adder cell with a per-bit B-complement stage and processes WIDTH-bit operands LSB-first, one bit per clock. A carry flip-flop holds the inter-bit carry. The carry is seeded with the two's-complement +1 for subtraction. Results and status flags are handed to the ULA result mux through a start/done handshake.

Parameters:
- WIDTH, 8, operand/result width in bits (>= 2).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a new operation; sampled only in IDLE.
- op  in  1  0 = add (A+B), 1 = subtract (A-B).
- a  in  WIDTH  operand A; captured on accepted start.
- b  in  WIDTH  operand B; captured on accepted start.
- busy  out  1  high while an operation is in progress (RUN or DONE).
- done  out  1  one-cycle pulse when the result is valid.
- result  out  WIDTH  sum/difference; held until the next accepted start.
- carry_out  out  1  final carry; for subtract, 1 = no borrow.
- overflow  out  1  signed overflow (only when the flags feature is compiled in).
- zero  out  1  result == 0 (only when the flags feature is compiled in).

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset: state = IDLE. busy=0, done=0, result=0, carry_out=0, overflow=0, zero=0. Shift registers, bit counter and carry flop are cleared.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - On start=1: load a_sh<=a, b_sh<=b, op_r<=op, carry<=op, cnt<=0; go to RUN.
  - start=0: stay in IDLE.
- RUN, each cycle:
  - be = b_sh[0] ^ op_r.
  - s = a_sh[0] ^ be ^ carry.
  - carry <= majority(a_sh[0], be, carry).
  - Shift a_sh and b_sh right by one.
  - res_sh <= {s, res_sh[WIDTH-1:1]}.
  - cnt <= cnt+1.
  - When cnt == WIDTH-1, go to DONE.
  - During the MSB cycle, also record c_msb_in = the carry entering that bit.
- DONE, exactly one cycle:
  - done=1.
  - result <= res_sh; carry_out <= final carry.
  - overflow <= c_msb_in ^ final carry; zero <= (result == 0).
  - Go to IDLE.
  - Outputs are registered: result/flags become visible in the same cycle done=1 and hold afterwards.
- Latency: start accepted at edge 0 → done high during cycle WIDTH+1. Throughput is one operation per WIDTH+2 cycles.
- start while busy=1 is ignored; no queuing. New a/b/op values do not disturb the operation in flight.
- start in the same cycle as done is ignored; it is accepted on the following IDLE cycle.
- rst asserted mid-operation: abort immediately. All outputs return to reset values and no done pulse is issued.
- rst has priority over start.
- Width rules:
  - cnt is $clog2(WIDTH) bits.
  - Arithmetic is modulo 2^WIDTH; subtraction is A + ~B + 1.

Optional Feature:
- Macro: SOMADOR_SERIAL_FLAGS_EN.
- Defined: overflow and zero computed as above; c_msb_in register present.
- Undefined: overflow and zero tied to 0; c_msb_in register and zero-detect logic omitted. Ports remain for interface stability.
- result, carry_out, done and timing are identical in both builds.

Decomposition:
- Package somador_serial_pkg holds:
  - state typedef (IDLE, RUN, DONE, 2 bits);
  - op encoding constants OP_ADD=1'b0, OP_SUB=1'b1.
- Sub-module somador_serial_celula: combinational 1-bit cell (A, B, Cin, select → R, Cout) doing B^select plus the full add.
- The top module contains the FSM, shift registers, counter, carry flop and flag logic.

Test Plan:
All cases use WIDTH=8 with flags enabled unless stated.
- Add 0x35+0x4A, start pulsed at cycle 0 → done in cycle 9, result=0x7F, carry_out=0, overflow=0, zero=0.
- Sub 0x10-0x10 → result=0x00, carry_out=1, zero=1, overflow=0.
- Add 0x7F+0x01 → result=0x80, overflow=1, carry_out=0. Same stimulus with SOMADOR_SERIAL_FLAGS_EN undefined → result=0x80, overflow=0, zero=0.
- Sub 0x00-0x01 → result=0xFF, carry_out=0 (borrow), overflow=0. Sub 0x80-0x01 → result=0x7F, overflow=1.
- Start add 0x01+0x01, then hold start=1 with a=0xFF, b=0xFF, op=1 during busy → single done, result=0x02. Second op starts only on the first IDLE cycle after done.
- Start add 0x35+0x4A, assert rst in cycle 4 → next cycle busy=0, result=0x00, no done pulse. A following start of 0x02+0x03 → result=0x05 after 9 cycles.

Source files
------------

// File: rtl/somador_serial_pkg.sv
// Shared types and constants for the bit-serial add/subtract unit.
package somador_serial_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/somador_serial_celula.sv
// One-bit full-adder cell; B is inverted when sel is set so the same cell serves subtraction.
module somador_serial_celula (
  input  logic a,
  input  logic b,
  input  logic cin,
  input  logic sel,
  output logic r,
  output logic cout
);

  logic be;

  always_comb begin
    be   = b ^ sel;
    r    = a ^ be ^ cin;
    cout = (a & be) | (a & cin) | (be & cin);
  end

endmodule

// File: rtl/somador_serial.sv
// Bit-serial A+B / A-B unit, LSB first, one bit per clock with a start/done handshake.
// Optional overflow/zero flags are compiled in with SOMADOR_SERIAL_FLAGS_EN.
module somador_serial
  import somador_serial_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_sh_reg, b_sh_reg, res_sh_reg;
  logic [CW-1:0]    cnt_reg;
  logic             op_reg;
  logic             carry_reg;
  logic [WIDTH-1:0] result_reg;
  logic             carry_out_reg;
  logic             cell_r, cell_cout;
  logic             last_bit;
  logic [WIDTH-1:0] res_word;

  somador_serial_celula u_celula (
    .a    (a_sh_reg[0]),
    .b    (b_sh_reg[0]),
    .cin  (carry_reg),
    .sel  (op_reg),
    .r    (cell_r),
    .cout (cell_cout)
  );

  assign last_bit = (cnt_reg == CNT_LAST);
  assign res_word = {cell_r, res_sh_reg[WIDTH-1:1]};

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_bit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Result and carry are latched on the MSB edge so they appear together with done.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh_reg      <= '0;
      b_sh_reg      <= '0;
      res_sh_reg    <= '0;
      cnt_reg       <= '0;
      op_reg        <= OP_ADD;
      carry_reg     <= 1'b0;
      result_reg    <= '0;
      carry_out_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: if (start) begin
          a_sh_reg  <= a;
          b_sh_reg  <= b;
          op_reg    <= op;
          carry_reg <= (op == OP_SUB);
          cnt_reg   <= '0;
        end
        RUN: begin
          carry_reg  <= cell_cout;
          a_sh_reg   <= {1'b0, a_sh_reg[WIDTH-1:1]};
          b_sh_reg   <= {1'b0, b_sh_reg[WIDTH-1:1]};
          res_sh_reg <= res_word;
          cnt_reg    <= cnt_reg + 1'b1;
          if (last_bit) begin
            result_reg    <= res_word;
            carry_out_reg <= cell_cout;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SOMADOR_SERIAL_FLAGS_EN
  logic c_msb_in;
  logic overflow_reg, zero_reg;

  // During the MSB cycle carry_reg is exactly the carry entering the sign bit.
  assign c_msb_in = carry_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_reg <= 1'b0;
      zero_reg     <= 1'b0;
    end else if (state_reg == RUN && last_bit) begin
      overflow_reg <= c_msb_in ^ cell_cout;
      zero_reg     <= (res_word == '0);
    end
  end

  assign overflow = overflow_reg;
  assign zero     = zero_reg;
`else
  assign overflow = 1'b0;
  assign zero     = 1'b0;
`endif

  assign busy      = (state_reg != IDLE);
  assign done      = (state_reg == DONE);
  assign result    = result_reg;
  assign carry_out = carry_out_reg;

endmodule

// File: tb/tb_somador_serial.sv
// Randomized and directed bench for somador_serial against an arithmetic reference model.
module tb_somador_serial;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, start, op;
  logic [W-1:0] a, b;
  logic         busy, done, carry_out, overflow, zero;
  logic [W-1:0] result;

  int checks = 0;
  int errors = 0;

  somador_serial #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed views of the operands.
  task automatic model(input logic [W-1:0] x, input logic [W-1:0] y, input logic o,
                       output logic [W-1:0] r, output logic c, output logic v, output logic z);
    int ux, uy, sx, sy, full, sres;
    ux = int'(x);
    uy = int'(y);
    sx = (ux >= 128) ? ux - 256 : ux;
    sy = (uy >= 128) ? uy - 256 : uy;
    if (o) begin
      full = ux - uy;
      c    = (ux >= uy);
      sres = sx - sy;
    end else begin
      full = ux + uy;
      c    = (full > 255);
      sres = sx + sy;
    end
    r = W'(full & 255);
`ifdef SOMADOR_SERIAL_FLAGS_EN
    v = (sres > 127) || (sres < -128);
    z = (r == 0);
`else
    v = 1'b0;
    z = 1'b0;
`endif
  endtask

  // Pulses start for one edge, waits for done and checks latency, result and flags.
  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic o);
    logic [W-1:0] er;
    logic ec, ev, ez;
    int n;
    model(x, y, o, er, ec, ev, ez);
    @(negedge clk);
    start = 1'b1; a = x; b = y; op = o;
    @(posedge clk); #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); op = 1'($urandom);
    check("busy_after_start", busy, 1'b1);
    n = 0;
    while (!done && n < 4 * W) begin
      @(posedge clk); #1;
      n++;
    end
    check("latency", n, W);
    check("result", result, er);
    check("carry_out", carry_out, ec);
    check("overflow", overflow, ev);
    check("zero", zero, ez);
    $display("%s a=%02h b=%02h -> result=%02h carry=%0b ov=%0b zero=%0b (cycles %0d)",
             o ? "SUB" : "ADD", x, y, result, carry_out, overflow, zero, n);
    @(posedge clk); #1;
    check("done_one_cycle", done, 1'b0);
    check("idle_after_done", busy, 1'b0);
    check("result_held", result, er);
  endtask

  initial begin
    logic [W-1:0] er;
    logic ec, ev, ez;
    int n, dones;

    rst = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_result", result, 8'h00);
    check("rst_carry", carry_out, 1'b0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_zero", zero, 1'b0);
    @(negedge clk); rst = 1'b0;

    run_op(8'h35, 8'h4A, 1'b0);
    run_op(8'h10, 8'h10, 1'b1);
    run_op(8'h7F, 8'h01, 1'b0);
    run_op(8'h00, 8'h01, 1'b1);
    run_op(8'h80, 8'h01, 1'b1);
    run_op(8'hFF, 8'h01, 1'b0);

    // start held high while busy must not queue a second operation
    @(negedge clk);
    start = 1'b1; a = 8'h01; b = 8'h01; op = 1'b0;
    @(posedge clk); #1;
    a = 8'hFF; b = 8'hFF; op = 1'b1;
    n = 0; dones = 0;
    while (!done && n < 4 * W) begin
      @(posedge clk); #1;
      n++;
    end
    check("hold_latency", n, W);
    check("hold_result", result, 8'h02);
    $display("ADD a=01 b=01 with start held -> result=%02h", result);
    @(posedge clk); #1;
    check("hold_idle_after_done", busy, 1'b0);
    @(posedge clk); #1;
    check("hold_second_accept", busy, 1'b1);
    start = 1'b0;
    n = 0;
    while (!done && n < 4 * W) begin
      @(posedge clk); #1;
      n++;
      if (done) dones++;
    end
    model(8'hFF, 8'hFF, 1'b1, er, ec, ev, ez);
    check("hold_second_done", dones, 1);
    check("hold_second_result", result, er);
    check("hold_second_carry", carry_out, ec);
    $display("SUB a=ff b=ff queued from held start -> result=%02h carry=%0b", result, carry_out);
    @(posedge clk); #1;

    // reset in the middle of an operation aborts it without a done pulse
    @(negedge clk);
    start = 1'b1; a = 8'h35; b = 8'h4A; op = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check("abort_busy", busy, 1'b0);
    check("abort_result", result, 8'h00);
    check("abort_carry", carry_out, 1'b0);
    @(negedge clk); rst = 1'b0;
    dones = 0;
    repeat (2 * W) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    check("abort_no_done", dones, 0);
    $display("ADD a=35 b=4a aborted by reset -> result=%02h busy=%0b", result, busy);
    run_op(8'h02, 8'h03, 1'b0);

    for (int i = 0; i < 40; i++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom));
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
